// File: rtl/axis_header_sched.sv
// Round-robin header scheduler for the AXI-Stream header inserter: grants one
// requester at a time, offers its header, then waits for the inserter's EOP.
module axis_header_sched #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic [NUM_SRC-1:0]                   req_valid,
    input  logic [NUM_SRC*DATA_WD-1:0]           req_data,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]      req_keep,
    input  logic [NUM_SRC*(BYTE_CNT_WD+1)-1:0]   req_cnt,
    output logic [NUM_SRC-1:0]                   req_ready,
    output logic                                 ins_valid,
    output logic [DATA_WD-1:0]                   ins_data,
    output logic [DATA_BYTE_WD-1:0]              ins_keep,
    output logic [BYTE_CNT_WD:0]                 ins_cnt,
    input  logic                                 ins_ready,
    input  logic                                 mon_valid,
    input  logic                                 mon_ready,
    input  logic                                 mon_last,
    output logic [$clog2(NUM_SRC)-1:0]           grant_id,
    output logic                                 busy,
    output logic                                 err_cnt,
    output logic                                 err_proto,
    output logic [15:0]                          pkt_count
);
    localparam int ID_WD = $clog2(NUM_SRC);
    localparam int CNT_W = BYTE_CNT_WD + 1;

    typedef enum logic [1:0] {IDLE, OFFER, WAIT_EOP} state_t;

    state_t                  state_reg, state_next;
    logic [ID_WD-1:0]        last_reg;
    logic [ID_WD-1:0]        grant_id_reg;
    logic [ID_WD-1:0]        winner;
    logic [DATA_WD-1:0]      data_reg;
    logic [DATA_BYTE_WD-1:0] keep_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    err_cnt_reg;
    logic                    err_proto_reg;
    logic [15:0]             pkt_count_reg;
    logic                    grant;
    logic                    cnt_ok;
    logic                    eop;

    logic [DATA_WD-1:0]      src_data [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] src_keep [NUM_SRC];
    logic [CNT_W-1:0]        src_cnt  [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_data[gi] = req_data[gi*DATA_WD +: DATA_WD];
            assign src_keep[gi] = req_keep[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
            assign src_cnt[gi]  = req_cnt[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // Search downward so the lowest offset after the last grant wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(last_reg) + k) % NUM_SRC;
            if (req_valid[idx]) begin
                winner = ID_WD'(idx);
            end
        end
    end

    assign grant     = (state_reg == IDLE) && en && (|req_valid);
    assign req_ready = grant ? (NUM_SRC'(1) << winner) : '0;
    assign cnt_ok    = (src_cnt[winner] != '0) && (src_cnt[winner] <= CNT_W'(DATA_BYTE_WD));
    assign eop       = mon_valid && mon_ready && mon_last;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (grant && cnt_ok) state_next = OFFER;
            OFFER:    if (ins_ready)       state_next = WAIT_EOP;
            WAIT_EOP: if (eop)             state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_reg      <= ID_WD'(NUM_SRC - 1);
            grant_id_reg  <= '0;
            data_reg      <= '0;
            keep_reg      <= '0;
            cnt_reg       <= '0;
            err_cnt_reg   <= 1'b0;
            err_proto_reg <= 1'b0;
            pkt_count_reg <= '0;
        end else begin
            state_reg   <= state_next;
            err_cnt_reg <= grant && !cnt_ok;
            // Illegal headers are still consumed and still move the pointer.
            if (grant) begin
                data_reg     <= src_data[winner];
                keep_reg     <= src_keep[winner];
                cnt_reg      <= src_cnt[winner];
                grant_id_reg <= winner;
                last_reg     <= winner;
            end
            if (eop && state_reg == WAIT_EOP) begin
                pkt_count_reg <= pkt_count_reg + 16'd1;
            end
            if (eop && state_reg != WAIT_EOP) begin
                err_proto_reg <= 1'b1;
            end
        end
    end

    assign ins_valid = (state_reg == OFFER);
    assign busy      = (state_reg != IDLE);
    assign ins_data  = data_reg;
    assign ins_keep  = keep_reg;
    assign ins_cnt   = cnt_reg;
    assign grant_id  = grant_id_reg;
    assign err_cnt   = err_cnt_reg;
    assign err_proto = err_proto_reg;
    assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_axis_header_sched.sv
// Randomized bench for axis_header_sched: transaction-level reference model,
// header scoreboard and a monitor that checks each header handshake.
module tb_axis_header_sched;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [NS-1:0]     req_valid = '0;
    logic [NS*DW-1:0]  req_data = '0;
    logic [NS*BW-1:0]  req_keep = '0;
    logic [NS*CW-1:0]  req_cnt = '0;
    logic [NS-1:0]     req_ready;
    logic              ins_valid;
    logic [DW-1:0]     ins_data;
    logic [BW-1:0]     ins_keep;
    logic [CW-1:0]     ins_cnt;
    logic              ins_ready = 1'b0;
    logic              mon_valid = 1'b0;
    logic              mon_ready = 1'b0;
    logic              mon_last = 1'b0;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err_cnt;
    logic              err_proto;
    logic [15:0]       pkt_count;

    axis_header_sched #(.NUM_SRC(NS), .DATA_WD(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep), .req_cnt(req_cnt),
        .req_ready(req_ready),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_keep(ins_keep), .ins_cnt(ins_cnt),
        .ins_ready(ins_ready),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
        .grant_id(grant_id), .busy(busy), .err_cnt(err_cnt), .err_proto(err_proto),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic [BW-1:0] k;
        logic [CW-1:0] c;
        int            id;
    } hdr_t;
    hdr_t sb[$];

    // Reference model: phase 0 = no header outstanding, 1 = header offered,
    // 2 = header taken, waiting for the packet's last beat.
    bit            started = 0;
    int            m_phase, m_last, m_gid, m_pkt, w;
    bit            m_errp, m_errc, g, m_eop;
    logic [DW-1:0] m_data;
    logic [BW-1:0] m_keep;
    logic [CW-1:0] m_cnt;
    logic [NS-1:0] exp_rr;

    function automatic int rr_pick(input int last, input logic [NS-1:0] v);
        for (int k = 1; k <= NS; k++) begin
            if (v[(last + k) % NS]) return (last + k) % NS;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_last = NS - 1; m_gid = 0; m_pkt = 0;
            m_errp = 0; m_errc = 0; m_data = '0; m_keep = '0; m_cnt = '0;
            sb.delete();
            started = 1;
        end else if (started) begin
            w = rr_pick(m_last, req_valid);
            g = (m_phase == 0) && en && (w >= 0);
            exp_rr = g ? (NS'(1) << w) : '0;
            chk("req_ready", req_ready, exp_rr);
            chk("busy", busy, m_phase != 0);
            chk("ins_valid", ins_valid, m_phase == 1);
            chk("pkt_count", pkt_count, m_pkt);
            chk("err_proto", err_proto, m_errp);
            chk("err_cnt", err_cnt, m_errc);
            chk("grant_id", grant_id, m_gid);
            chk("ins_data_hold", ins_data, m_data);
            chk("ins_keep_hold", ins_keep, m_keep);
            chk("ins_cnt_hold", ins_cnt, m_cnt);

            m_eop = mon_valid && mon_ready && mon_last;
            if (m_eop && m_phase != 2) m_errp = 1;
            m_errc = 0;
            if (g) begin
                m_data = req_data[w*DW +: DW];
                m_keep = req_keep[w*BW +: BW];
                m_cnt  = req_cnt[w*CW +: CW];
                m_gid  = w;
                m_last = w;
                if (m_cnt >= 1 && m_cnt <= BW) begin
                    m_phase = 1;
                    sb.push_back('{d: m_data, k: m_keep, c: m_cnt, id: w});
                end else begin
                    m_errc = 1;
                end
            end else if (m_phase == 1 && ins_ready) begin
                m_phase = 2;
            end else if (m_phase == 2 && m_eop) begin
                m_phase = 0;
                m_pkt = (m_pkt + 1) % 65536;
            end
        end
    end

    hdr_t e;
    always @(negedge clk) begin
        if (rst_n && started && ins_valid === 1'b1 && ins_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hdr_unexpected: got data %0h, expected no header", ins_data);
            end else begin
                e = sb.pop_front();
                chk("hdr_data", ins_data, e.d);
                chk("hdr_keep", ins_keep, e.k);
                chk("hdr_cnt", ins_cnt, e.c);
                chk("hdr_src", grant_id, e.id);
            end
        end
    end

    // Stimulus knobs and the bench's role as inserter/downstream.
    bit manual = 1;
    bit all_req = 0;
    bit want_reset = 0;
    int p_req = 30, p_bad = 0, p_en = 100, p_rdy = 50, p_perr = 0, p_mon = 100;
    int pkt_len_fixed = 4;
    bit pkt_active = 0;
    int beats_left = 0;
    bit hs_hdr, hs_mon;

    task automatic step();
        @(negedge clk);
        hs_hdr = rst_n && ins_valid && ins_ready;
        hs_mon = rst_n && mon_valid && mon_ready;
        @(posedge clk);
        #1;
        if (hs_mon && pkt_active) begin
            beats_left--;
            if (beats_left == 0) pkt_active = 0;
        end
        if (hs_hdr) begin
            pkt_active = 1;
            beats_left = (pkt_len_fixed > 0) ? pkt_len_fixed : int'($urandom_range(1, 4));
        end
        if (want_reset && pkt_active) begin
            rst_n = 0;
            want_reset = 0;
            pkt_active = 0;
        end else begin
            rst_n = 1;
        end
        if (pkt_active) begin
            mon_valid = ($urandom % 100) < p_mon;
            mon_ready = ($urandom % 100) < p_mon;
            mon_last  = (beats_left == 1);
        end else begin
            mon_valid = rst_n && (($urandom % 100) < p_perr);
            mon_ready = mon_valid;
            mon_last  = mon_valid;
        end
        if (!manual) begin
            for (int i = 0; i < NS; i++) begin
                req_valid[i] = all_req ? 1'b1 : (($urandom % 100) < p_req);
                req_data[i*DW +: DW] = $urandom;
                req_keep[i*BW +: BW] = BW'($urandom);
                req_cnt[i*CW +: CW]  = (($urandom % 100) < p_bad) ? CW'($urandom_range(0, 7))
                                                                   : CW'($urandom_range(1, 4));
            end
            en        = ($urandom % 100) < p_en;
            ins_ready = ($urandom % 100) < p_rdy;
        end
    endtask

    initial begin
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;

        // Single source: src2, header stalled for five cycles, then a 4-beat packet.
        en = 1;
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 32'hA1B2C3D4;
        req_keep[2*BW +: BW] = 4'hF;
        req_cnt[2*CW +: CW]  = 3'd3;
        ins_ready = 0;
        step();
        req_valid = '0;
        repeat (5) step();
        ins_ready = 1;
        step();
        ins_ready = 0;
        repeat (8) step();

        // Illegal counts on src1 then src3.
        req_valid = 4'b0010;
        req_cnt[1*CW +: CW] = 3'd0;
        step();
        req_valid = 4'b1000;
        req_cnt[3*CW +: CW] = 3'd5;
        step();
        req_valid = '0;
        repeat (3) step();

        // Continuous requests from all sources, 2-beat packets.
        manual = 0; all_req = 1; pkt_len_fixed = 2; p_rdy = 70; p_mon = 80;
        repeat (300) step();

        // Sparse requests with frequent illegal counts and en toggling.
        all_req = 0; p_req = 30; p_bad = 40; p_en = 70;
        repeat (400) step();

        // Everything random, including protocol errors and mid-packet resets.
        pkt_len_fixed = 0; p_perr = 2; p_bad = 15; p_rdy = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i == 700 || i == 1800) want_reset = 1;
            if (i == 2500) all_req = 1;
            step();
        end
        manual = 1;
        req_valid = '0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
